// File: rtl/piso_stream_serializer_if.sv
// Handshake bundle for the parallel-in / serial-out stream serializer.
// Upstream word channel plus downstream serial bit channel.
interface piso_stream_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] pi_data;
    logic             pi_valid;
    logic             pi_ready;
    logic             so_en;
    logic             so;
    logic             so_valid;
    logic             so_first;
    logic             so_last;
    logic             busy;

    modport master (
        output pi_data,
        output pi_valid,
        output so_en,
        input  pi_ready,
        input  so,
        input  so_valid,
        input  so_first,
        input  so_last,
        input  busy
    );

    modport slave (
        input  pi_data,
        input  pi_valid,
        input  so_en,
        output pi_ready,
        output so,
        output so_valid,
        output so_first,
        output so_last,
        output busy
    );
endinterface

// File: rtl/piso_stream_serializer.sv
// Parallel-word to serial-bit stream serializer with a one-word holding
// buffer so consecutive words leave with no idle gap between them.
module piso_stream_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                     clk,
    input logic                     rst,
    piso_stream_serializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hb_q, hb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hb_full_q, hb_full_d;

    logic             ready;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sh_shifted;

    assign ready    = rst & ~hb_full_q;
    assign accept   = bus.pi_valid & ready;
    assign last_bit = (cnt_q == CNT_LAST);

    // Move the next bit toward whichever end drives the serial line.
    assign sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sh_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            hb_q      <= '0;
            cnt_q     <= '0;
            hb_full_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            hb_q      <= hb_d;
            cnt_q     <= cnt_d;
            hb_full_q <= hb_full_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        hb_d      = hb_q;
        cnt_d     = cnt_q;
        hb_full_d = hb_full_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = bus.pi_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.so_en && last_bit) begin
                    // Buffered word wins over a fresh one to keep order.
                    if (hb_full_q) begin
                        sh_d      = hb_q;
                        hb_full_d = 1'b0;
                        cnt_d     = '0;
                    end else if (accept) begin
                        sh_d  = bus.pi_data;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (bus.so_en) begin
                        sh_d  = sh_shifted;
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (accept) begin
                        hb_d      = bus.pi_data;
                        hb_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.so       = 1'b0;
        bus.so_valid = 1'b0;
        bus.so_first = 1'b0;
        bus.so_last  = 1'b0;
        if (state_q == SHIFT) begin
            bus.so       = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
            bus.so_valid = 1'b1;
            bus.so_first = (cnt_q == '0);
            bus.so_last  = last_bit;
        end
    end

    assign bus.pi_ready = ready;
    assign bus.busy     = (state_q == SHIFT) | hb_full_q;
endmodule

// File: tb/tb_piso_stream_serializer.sv
// Bench for piso_stream_serializer: vector table, corner sequences and a
// word-queue reference model run against MSB-first and LSB-first instances.
module tb_piso_stream_serializer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         pv;
    logic [W-1:0] pd;
    logic         en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_stream_serializer_if #(.WIDTH(W)) mif ();
    piso_stream_serializer_if #(.WIDTH(W)) lif ();

    assign mif.pi_data  = pd;
    assign mif.pi_valid = pv;
    assign mif.so_en    = en;
    assign lif.pi_data  = pd;
    assign lif.pi_valid = pv;
    assign lif.so_en    = en;

    piso_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    piso_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (lif)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: queue of accepted words plus the bit position of the head word.
    logic [W-1:0] mq[$];
    int           pos = 0;
    bit           mdl_on = 0;

    always @(posedge clk) begin
        bit acc;
        if (!rst) begin
            mq.delete();
            pos    = 0;
            mdl_on = 1;
        end else begin
            acc = pv && (mq.size() < 2);
            if (mq.size() > 0 && en) begin
                if (pos == W - 1) begin
                    void'(mq.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            if (acc) mq.push_back(pd);
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] hw;
        logic e_rdy, e_v, e_f, e_l, e_b, e_m, e_ls;
        if (mdl_on) begin
            e_rdy = rst && (mq.size() < 2);
            e_v   = 1'b0;
            e_f   = 1'b0;
            e_l   = 1'b0;
            e_b   = 1'b0;
            e_m   = 1'b0;
            e_ls  = 1'b0;
            if (mq.size() > 0) begin
                hw   = mq[0];
                e_v  = 1'b1;
                e_b  = 1'b1;
                e_f  = (pos == 0);
                e_l  = (pos == W - 1);
                e_m  = hw[W-1-pos];
                e_ls = hw[pos];
            end
            chk("mdl_msb_ready", mif.pi_ready, e_rdy);
            chk("mdl_msb_so",    mif.so,       e_m);
            chk("mdl_msb_valid", mif.so_valid, e_v);
            chk("mdl_msb_first", mif.so_first, e_f);
            chk("mdl_msb_last",  mif.so_last,  e_l);
            chk("mdl_msb_busy",  mif.busy,     e_b);
            chk("mdl_lsb_ready", lif.pi_ready, e_rdy);
            chk("mdl_lsb_so",    lif.so,       e_ls);
            chk("mdl_lsb_valid", lif.so_valid, e_v);
            chk("mdl_lsb_first", lif.so_first, e_f);
            chk("mdl_lsb_last",  lif.so_last,  e_l);
            chk("mdl_lsb_busy",  lif.busy,     e_b);
        end
    end

    typedef struct {
        logic         r;
        logic         v;
        logic [W-1:0] d;
        logic         e;
        logic         rdy;
        logic         so;
        logic         sv;
        logic         sf;
        logic         sl;
        logic         bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, v, input logic [W-1:0] d,
                                input logic e, rdy, so, sv, sf, sl, bsy);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.e = e;
        x.rdy = rdy; x.so = so; x.sv = sv;
        x.sf = sf; x.sl = sl; x.bsy = bsy;
        return x;
    endfunction

    task automatic drive(input logic r, v, input logic [W-1:0] d, input logic e);
        rst = r;
        pv  = v;
        pd  = d;
        en  = e;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nlast;
        logic exp_so[6];
        logic exp_f[6];

        drive(1'b0, 1'b1, 4'hF, 1'b1);
        next_cycle();

        // Held in reset with a valid word offered: nothing may get in.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", mif.pi_ready, 1'b0);
            chk("rst_valid", mif.so_valid, 1'b0);
            chk("rst_so",    mif.so,       1'b0);
            next_cycle();
        end
        drive(1'b1, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_ready", mif.pi_ready, 1'b1);
            chk("post_rst_valid", mif.so_valid, 1'b0);
            chk("post_rst_busy",  mif.busy,     1'b0);
            next_cycle();
        end

        // Single word 1011, then back-to-back A,5 with hb filling.
        tbl.push_back(mk(1, 1, 4'hB, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h0, 1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 1, 1, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 4'hA, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 4'h5, 1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 1, 1, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 4'h0, 1, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].e);
            @(negedge clk);
            chk("tbl_ready", mif.pi_ready, tbl[i].rdy);
            chk("tbl_so",    mif.so,       tbl[i].so);
            chk("tbl_valid", mif.so_valid, tbl[i].sv);
            chk("tbl_first", mif.so_first, tbl[i].sf);
            chk("tbl_last",  mif.so_last,  tbl[i].sl);
            chk("tbl_busy",  mif.busy,     tbl[i].bsy);
            next_cycle();
        end

        // Stall: 1100 with the second bit held for two extra cycles.
        drive(1'b1, 1'b1, 4'b1100, 1'b1);
        next_cycle();
        exp_so = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_f  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        nlast  = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 4'h0, (i == 1 || i == 2) ? 1'b0 : 1'b1);
            @(negedge clk);
            chk("stall_valid", mif.so_valid, 1'b1);
            chk("stall_so",    mif.so,       exp_so[i]);
            chk("stall_first", mif.so_first, exp_f[i]);
            if (mif.so_last === 1'b1) nlast++;
            next_cycle();
        end
        checks++;
        if (nlast != 1) begin
            errors++;
            $display("FAIL stall_last_count: got %0d expected 1", nlast);
        end
        @(negedge clk);
        chk("stall_idle", mif.so_valid, 1'b0);
        next_cycle();

        // LSB-first instance: 0001 leaves as 1,0,0,0.
        drive(1'b1, 1'b1, 4'b0001, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lsb_so",    lif.so,       (i == 0) ? 1'b1 : 1'b0);
            chk("lsb_first", lif.so_first, (i == 0) ? 1'b1 : 1'b0);
            chk("lsb_last",  lif.so_last,  (i == 3) ? 1'b1 : 1'b0);
            next_cycle();
        end

        // Reset with a word in flight and another buffered.
        drive(1'b1, 1'b1, 4'hC, 1'b1);
        next_cycle();
        drive(1'b1, 1'b1, 4'h3, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 4'h0, 1'b1);
        @(negedge clk);
        chk("mid_hb_ready", mif.pi_ready, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_rst_valid", mif.so_valid, 1'b0);
            chk("mid_rst_busy",  mif.busy,     1'b0);
            chk("mid_rst_ready", mif.pi_ready, 1'b1);
            next_cycle();
        end

        // Random traffic; the reference model checks every cycle.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 9) < 6),
                  W'($urandom),
                  ($urandom_range(0, 3) != 0));
            next_cycle();
        end

        drive(1'b1, 1'b0, 4'h0, 1'b1);
        repeat (12) next_cycle();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
